spi_rx_wide: RTL and testbench

Parametrised SPI receive shifter, successor to the single-lane 32-bit receiver in the APB-to-SPI datapath. It samples single, dual or quad data lanes on strobes from the SPI clock generator, with a runtime-selectable bit order. Words are assembled in a shift register and handed to the RX FIFO through a registered valid/ready output stage. On backpressure it holds the completed word and raises a stall flag so the clock generator can freeze SCLK instead of losing bits.

---
 rtl/spi_rx_wide.sv | 213 +++++++++++++++++++++
 tb/tb_spi_rx_wide.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_wide.sv
// spi_rx_wide: SPI receive shifter, 1/2/4 lanes, MSB/LSB-first order,
// registered valid/ready output with stall (HOLD) on backpressure.
//
// Optional feature macro: SPI_RX_QUAD_EN
//   defined   -> mode 2'b10 samples all four lanes (quad)
//   undefined -> quad logic removed; mode 2'b10 behaves as single,
//                sdi_i[3:2] ignored; port list unchanged
//
// Ports:
//   clk_i, rst_n_i       clock, async active-low reset
//   en_i, abort_i        start request (IDLE), synchronous abort
//   mode_i, lsb_first_i  lane mode and bit order, latched at start
//   rx_edge_i, sdi_i     sample strobe and data lanes
//   rx_length_i/_updt_i  transfer length in bits and its load strobe
//   rx_data_o/_vld_o     output word and valid
//   rx_data_rdy_i        consumer ready
//   rx_done_o            pulse with the last word of a transfer
//   rx_stall_o           word held, SCLK must be frozen
//   busy_o               FSM not in IDLE
module spi_rx_wide #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  input  logic              lsb_first_i,
  input  logic              rx_edge_i,
  input  logic [3:0]        sdi_i,
  input  logic [LEN_W-1:0]  rx_length_i,
  input  logic              rx_length_updt_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_data_vld_o,
  input  logic              rx_data_rdy_i,
  output logic              rx_done_o,
  output logic              rx_stall_o,
  output logic              busy_o
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] WFULL = CW'(DATA_W);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RECV = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_target;
  logic [LEN_W-1:0]  r_len;
  logic [1:0]        r_mode;
  logic              r_lsb;
  logic [DATA_W-1:0] r_sh;
  logic [CW-1:0]     r_wcnt;
  logic [LEN_W:0]    r_bcnt;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  logic              r_vld;
  logic              r_done;

  logic              w_dual;
  logic [2:0]        w_step;
  logic [3:0]        w_msbv;
  logic [3:0]        w_lsbv;
  logic [DATA_W-1:0] w_sh_nx;
  logic [CW-1:0]     w_wcnt_nx;
  logic [LEN_W:0]    w_bcnt_nx;
  logic              w_last;
  logic              w_full;
  logic              w_free;

`ifdef SPI_RX_QUAD_EN
  logic w_quad;
  assign w_quad = (r_mode == 2'b10);
`else
  logic w_unused;
  assign w_unused = ^sdi_i[3:2];
`endif

  // Mode 2'b11 is reserved and falls through to single.
  assign w_dual = (r_mode == 2'b01);

  // w_msbv: new bits, first stream bit most significant.
  // w_lsbv: new bits, first stream bit at bit 0.
  always_comb begin
    w_step = 3'd1;
    w_msbv = {3'b000, sdi_i[0]};
    w_lsbv = {3'b000, sdi_i[0]};
    unique case (1'b1)
`ifdef SPI_RX_QUAD_EN
      w_quad: begin
        w_step = 3'd4;
        w_msbv = sdi_i;
        w_lsbv = {sdi_i[0], sdi_i[1], sdi_i[2], sdi_i[3]};
      end
`endif
      w_dual: begin
        w_step = 3'd2;
        w_msbv = {2'b00, sdi_i[1:0]};
        w_lsbv = {2'b00, sdi_i[0], sdi_i[1]};
      end
      default: ;
    endcase
  end

  // The shift register is cleared at every word start, so the
  // LSB-first path can OR bits in at the running word position and
  // both orders leave a partial word right-aligned.
  assign w_sh_nx = r_lsb
    ? (r_sh | (DATA_W'(w_lsbv) << r_wcnt))
    : ((r_sh << w_step) | DATA_W'(w_msbv));

  assign w_wcnt_nx = r_wcnt + CW'(w_step);
  assign w_bcnt_nx = r_bcnt + (LEN_W+1)'(w_step);
  assign w_last    = (w_bcnt_nx >= {1'b0, r_len});
  assign w_full    = (w_wcnt_nx == WFULL);
  assign w_free    = !r_vld || rx_data_rdy_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_len    <= '0;
      r_mode   <= '0;
      r_lsb    <= 1'b0;
      r_sh     <= '0;
      r_wcnt   <= '0;
      r_bcnt   <= '0;
      r_last   <= 1'b0;
      r_data   <= '0;
      r_vld    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (rx_length_updt_i)
        r_target <= rx_length_i;
      // Accept; a load below in the same cycle re-asserts valid.
      if (r_vld && rx_data_rdy_i)
        r_vld <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (!abort_i && en_i && (r_target != '0)) begin
            r_mode  <= mode_i;
            r_lsb   <= lsb_first_i;
            r_len   <= r_target;
            r_sh    <= '0;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
            r_last  <= 1'b0;
            r_state <= S_RECV;
          end
        end

        S_RECV: begin
          if (abort_i) begin
            r_sh    <= '0;
            r_wcnt  <= '0;
            r_last  <= 1'b0;
            r_state <= S_IDLE;
          end else if (rx_edge_i) begin
            r_bcnt <= w_bcnt_nx;
            if (w_full || w_last) begin
              if (w_free) begin
                r_data <= w_sh_nx;
                r_vld  <= 1'b1;
                r_done <= w_last;
                r_sh   <= '0;
                r_wcnt <= '0;
                if (w_last)
                  r_state <= S_IDLE;
              end else begin
                // Output busy: park the word here and stall SCLK.
                r_sh    <= w_sh_nx;
                r_last  <= w_last;
                r_state <= S_HOLD;
              end
            end else begin
              r_sh   <= w_sh_nx;
              r_wcnt <= w_wcnt_nx;
            end
          end
        end

        S_HOLD: begin
          if (abort_i) begin
            r_sh    <= '0;
            r_wcnt  <= '0;
            r_last  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_vld && rx_data_rdy_i) begin
            r_data  <= r_sh;
            r_vld   <= 1'b1;
            r_done  <= r_last;
            r_sh    <= '0;
            r_wcnt  <= '0;
            r_state <= r_last ? S_IDLE : S_RECV;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_data_o     = r_data;
  assign rx_data_vld_o = r_vld;
  assign rx_done_o     = r_done;
  assign rx_stall_o    = (r_state == S_HOLD);
  assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_rx_wide.sv
// tb_spi_rx_wide: self-checking bench for spi_rx_wide.
// Directed scenarios plus randomized transfers against a bit-stream model.
module tb_spi_rx_wide;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          lsb = 1'b0;
  logic          edge_s = 1'b0;
  logic [3:0]    sdi = 4'h0;
  logic [LW-1:0] len_i = '0;
  logic          updt = 1'b0;
  logic [DW-1:0] rx_data_o;
  logic          rx_data_vld_o;
  logic          rdy = 1'b0;
  logic          rx_done_o;
  logic          rx_stall_o;
  logic          busy_o;

  always #5 clk = ~clk;

  spi_rx_wide #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .en_i            (en),
    .abort_i         (abort),
    .mode_i          (mode),
    .lsb_first_i     (lsb),
    .rx_edge_i       (edge_s),
    .sdi_i           (sdi),
    .rx_length_i     (len_i),
    .rx_length_updt_i(updt),
    .rx_data_o       (rx_data_o),
    .rx_data_vld_o   (rx_data_vld_o),
    .rx_data_rdy_i   (rdy),
    .rx_done_o       (rx_done_o),
    .rx_stall_o      (rx_stall_o),
    .busy_o          (busy_o)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [DW-1:0] got[$];
  bit  sbits[$];
  logic [DW-1:0] exp_q[$];
  bit  rand_rdy = 1'b0;
  int  cur_mode = 0;
  bit  cur_lsb = 1'b0;

  // Passive collector of accepted words and done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done_o) done_cnt++;
      if (rx_data_vld_o && rdy) got.push_back(rx_data_o);
    end
  end

  function automatic int bpe(input int m);
    if (m == 1) return 2;
`ifdef SPI_RX_QUAD_EN
    if (m == 2) return 4;
`endif
    return 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic push_bits(input logic [3:0] s);
    case (bpe(cur_mode))
      4: begin
        sbits.push_back(s[3]); sbits.push_back(s[2]);
        sbits.push_back(s[1]); sbits.push_back(s[0]);
      end
      2: begin
        sbits.push_back(s[1]); sbits.push_back(s[0]);
      end
      default: sbits.push_back(s[0]);
    endcase
  endtask

  task automatic strobe(input logic [3:0] s, input bit keep);
    sdi = s;
    edge_s = 1'b1;
    if (keep) push_bits(s);
    step();
    edge_s = 1'b0;
  endtask

  task automatic start(input int m, input bit l, input int len);
    len_i = LW'(len);
    updt = 1'b1;
    step();
    updt = 1'b0;
    mode = 2'(m);
    lsb = l;
    cur_mode = m;
    cur_lsb = l;
    sbits.delete();
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  // Expected words: cut the sampled stream into DW-bit chunks,
  // last chunk possibly short and right-aligned.
  task automatic build_exp();
    int idx;
    int cnt;
    logic [DW-1:0] val;
    exp_q.delete();
    idx = 0;
    while (idx < sbits.size()) begin
      cnt = (sbits.size() - idx < DW) ? sbits.size() - idx : DW;
      val = '0;
      for (int k = 0; k < cnt; k++) begin
        if (cur_lsb) val = val | (DW'(sbits[idx+k]) << k);
        else         val = (val << 1) | DW'(sbits[idx+k]);
      end
      exp_q.push_back(val);
      idx += cnt;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    rand_rdy = 1'b0;
    rdy = 1'b1;
    n = 0;
    while ((busy_o || rx_data_vld_o) && n < 500) begin
      step();
      n++;
    end
    step();
    tests++;
    if (n >= 500) begin
      fails++;
      $display("FAIL %s_timeout busy=%b vld=%b required idle", nm, busy_o, rx_data_vld_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    tests++;
    if (rx_data_o !== '0) begin fails++; $display("FAIL rst_data got=%h exp=0", rx_data_o); end
    tests++;
    if (rx_data_vld_o !== 1'b0) begin fails++; $display("FAIL rst_vld got=%b exp=0", rx_data_vld_o); end
    tests++;
    if (rx_done_o !== 1'b0) begin fails++; $display("FAIL rst_done got=%b exp=0", rx_done_o); end
    tests++;
    if (rx_stall_o !== 1'b0) begin fails++; $display("FAIL rst_stall got=%b exp=0", rx_stall_o); end
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    rst_n = 1'b1;
    step();
    en = 1'b1;
    step();
    en = 1'b0;
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL zero_target_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_single_msb();
    logic [31:0] w;
    int d0;
    w = 32'hA5C30F96;
    rdy = 1'b1;
    start(0, 0, 32);
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) begin
      strobe({3'($urandom()), w[31-i]}, 1'b1);
      if (i == 30) begin
        tests++;
        if (rx_data_vld_o !== 1'b0) begin fails++; $display("FAIL single_early_vld got=%b exp=0", rx_data_vld_o); end
      end
    end
    tests++;
    if (rx_data_vld_o !== 1'b1) begin fails++; $display("FAIL single_vld got=%b exp=1", rx_data_vld_o); end
    tests++;
    if (rx_done_o !== 1'b1) begin fails++; $display("FAIL single_done got=%b exp=1", rx_done_o); end
    tests++;
    if (rx_data_o !== DW'(w)) begin fails++; $display("FAIL single_data got=%h exp=%h", rx_data_o, w); end
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL single_busy got=%b exp=0", busy_o); end
    step();
    tests++;
    if (rx_done_o !== 1'b0) begin fails++; $display("FAIL single_done_width got=%b exp=0", rx_done_o); end
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt - d0); end
  endtask

`ifdef SPI_RX_QUAD_EN
  task automatic test_quad_msb();
    rdy = 1'b1;
    start(2, 0, 40);
    for (int i = 0; i < 10; i++) begin
      strobe(4'(i + 1), 1'b1);
      if (i == 7) begin
        tests++;
        if (rx_data_o !== DW'(32'h12345678) || rx_done_o !== 1'b0) begin
          fails++; $display("FAIL quad_w0 got=%h/%b exp=12345678/0", rx_data_o, rx_done_o);
        end
      end
    end
    tests++;
    if (rx_data_o !== DW'(32'h9A) || rx_done_o !== 1'b1) begin
      fails++; $display("FAIL quad_w1 got=%h/%b exp=0000009a/1", rx_data_o, rx_done_o);
    end
    wait_idle("quad");
  endtask
`else
  task automatic test_quad_disabled();
    logic [7:0] b;
    b = 8'h3C;
    rdy = 1'b1;
    start(2, 0, 8);
    for (int i = 0; i < 8; i++) strobe({3'($urandom()), b[7-i]}, 1'b1);
    tests++;
    if (rx_data_o !== DW'(32'h3C) || rx_done_o !== 1'b1) begin
      fails++; $display("FAIL noquad got=%h/%b exp=0000003c/1", rx_data_o, rx_done_o);
    end
    wait_idle("noquad");
  endtask
`endif

  task automatic test_dual_lsb();
    logic [1:0] p[4];
    p[0] = 2'b10; p[1] = 2'b11; p[2] = 2'b00; p[3] = 2'b01;
    rdy = 1'b1;
    start(1, 1, 8);
    for (int i = 0; i < 4; i++) strobe({2'($urandom()), p[i]}, 1'b1);
    tests++;
    if (rx_data_o !== DW'(32'h8D) || rx_done_o !== 1'b1) begin
      fails++; $display("FAIL dual_lsb got=%h/%b exp=0000008d/1", rx_data_o, rx_done_o);
    end
    wait_idle("dual");
  endtask

  task automatic test_random();
    int m, len, ne, g0, d0, n;
    bit l;
    for (int it = 0; it < 24; it++) begin
      m = $urandom_range(0, 3);
      l = 1'($urandom_range(0, 1));
      len = (it % 6 == 0) ? 32 * $urandom_range(1, 3) : $urandom_range(1, 100);
      rand_rdy = 1'b1;
      g0 = got.size();
      d0 = done_cnt;
      start(m, l, len);
      ne = (len + bpe(m) - 1) / bpe(m);
      for (int e = 0; e < ne; e++) begin
        n = 0;
        while (rx_stall_o && n < 1000) begin step(); n++; end
        if (n >= 1000) begin
          tests++; fails++;
          $display("FAIL rand_stall_timeout it=%0d stall=%b", it, rx_stall_o);
        end
        if ($urandom_range(0, 3) == 0) step();
        strobe(4'($urandom()), 1'b1);
      end
      wait_idle("rand");
      build_exp();
      tests++;
      if (got.size() - g0 != exp_q.size()) begin
        fails++;
        $display("FAIL rand_count it=%0d m=%0d len=%0d got=%0d exp=%0d",
                 it, m, len, got.size() - g0, exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          tests++;
          if (got[g0+k] !== exp_q[k]) begin
            fails++;
            $display("FAIL rand_word it=%0d k=%0d got=%h exp=%h", it, k, got[g0+k], exp_q[k]);
          end
        end
      end
      tests++;
      if (done_cnt - d0 != 1) begin
        fails++; $display("FAIL rand_done it=%0d got=%0d exp=1", it, done_cnt - d0);
      end
    end
  endtask

  task automatic test_backpressure();
    int g0, d0;
    rdy = 1'b0;
    g0 = got.size();
    d0 = done_cnt;
    start(0, 0, 96);
    for (int i = 0; i < 64; i++) begin
      strobe(4'($urandom()), 1'b1);
      if (i == 31) begin
        tests++;
        if (rx_data_vld_o !== 1'b1 || rx_stall_o !== 1'b0) begin
          fails++; $display("FAIL bp_w0 vld=%b stall=%b exp=1/0", rx_data_vld_o, rx_stall_o);
        end
      end
    end
    build_exp();
    tests++;
    if (rx_stall_o !== 1'b1) begin fails++; $display("FAIL bp_stall got=%b exp=1", rx_stall_o); end
    tests++;
    if (rx_data_o !== exp_q[0]) begin fails++; $display("FAIL bp_hold_data got=%h exp=%h", rx_data_o, exp_q[0]); end
    for (int i = 0; i < 6; i++) strobe(4'($urandom()), 1'b0);
    tests++;
    if (rx_stall_o !== 1'b1 || busy_o !== 1'b1 || rx_data_o !== exp_q[0]) begin
      fails++; $display("FAIL bp_drop stall=%b busy=%b data=%h exp=1/1/%h",
                        rx_stall_o, busy_o, rx_data_o, exp_q[0]);
    end
    rdy = 1'b1;
    step();
    tests++;
    if (rx_data_vld_o !== 1'b1 || rx_data_o !== exp_q[1]) begin
      fails++; $display("FAIL bp_load vld=%b data=%h exp=1/%h", rx_data_vld_o, rx_data_o, exp_q[1]);
    end
    tests++;
    if (rx_stall_o !== 1'b0) begin fails++; $display("FAIL bp_unstall got=%b exp=0", rx_stall_o); end
    for (int i = 0; i < 32; i++) strobe(4'($urandom()), 1'b1);
    build_exp();
    tests++;
    if (rx_done_o !== 1'b1 || rx_data_o !== exp_q[2]) begin
      fails++; $display("FAIL bp_w2 done=%b data=%h exp=1/%h", rx_done_o, rx_data_o, exp_q[2]);
    end
    wait_idle("bp");
    tests++;
    if (got.size() - g0 != 3) begin
      fails++; $display("FAIL bp_count got=%0d exp=3", got.size() - g0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got[g0+k] !== exp_q[k]) begin
          fails++; $display("FAIL bp_word k=%0d got=%h exp=%h", k, got[g0+k], exp_q[k]);
        end
      end
    end
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL bp_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int g0, d0;
    rdy = 1'b1;
    g0 = got.size();
    d0 = done_cnt;
    start(0, 0, 32);
    for (int i = 0; i < 10; i++) strobe(4'($urandom()), 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if (busy_o !== 1'b0 || rx_data_vld_o !== 1'b0) begin
      fails++; $display("FAIL abort_state busy=%b vld=%b exp=0/0", busy_o, rx_data_vld_o);
    end
    en = 1'b1;
    abort = 1'b1;
    step();
    en = 1'b0;
    abort = 1'b0;
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_en busy=%b exp=0", busy_o); end
    step();
    tests++;
    if (done_cnt != d0 || got.size() != g0) begin
      fails++; $display("FAIL abort_out done=%0d words=%0d exp=0/0", done_cnt - d0, got.size() - g0);
    end
    start(0, 1, 32);
    for (int i = 0; i < 32; i++) strobe(4'($urandom()), 1'b1);
    wait_idle("abort");
    build_exp();
    tests++;
    if (got.size() - g0 != 1 || got[got.size()-1] !== exp_q[0]) begin
      fails++; $display("FAIL abort_restart n=%0d got=%h exp=%h",
                        got.size() - g0, got[got.size()-1], exp_q[0]);
    end
  endtask

  task automatic test_length_update();
    int g0;
    rdy = 1'b1;
    g0 = got.size();
    start(0, 0, 8);
    for (int i = 0; i < 3; i++) strobe(4'($urandom()), 1'b1);
    len_i = LW'(16);
    updt = 1'b1;
    strobe(4'($urandom()), 1'b1);
    updt = 1'b0;
    for (int i = 0; i < 4; i++) strobe(4'($urandom()), 1'b1);
    build_exp();
    tests++;
    if (rx_done_o !== 1'b1 || rx_data_o !== exp_q[0]) begin
      fails++; $display("FAIL lenupd_first done=%b data=%h exp=1/%h", rx_done_o, rx_data_o, exp_q[0]);
    end
    sbits.delete();
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 8; i++) strobe(4'($urandom()), 1'b1);
    tests++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL lenupd_busy got=%b exp=1", busy_o); end
    for (int i = 0; i < 8; i++) strobe(4'($urandom()), 1'b1);
    wait_idle("lenupd");
    build_exp();
    tests++;
    if (got.size() - g0 != 2 || got[got.size()-1] !== exp_q[0]) begin
      fails++; $display("FAIL lenupd_second n=%0d got=%h exp=%h",
                        got.size() - g0, got[got.size()-1], exp_q[0]);
    end
  endtask

  task automatic test_reset_hold();
    rdy = 1'b0;
    start(0, 0, 64);
    for (int i = 0; i < 64; i++) strobe(4'($urandom()), 1'b1);
    tests++;
    if (rx_stall_o !== 1'b1) begin fails++; $display("FAIL rsth_stall got=%b exp=1", rx_stall_o); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (rx_data_o !== '0 || rx_data_vld_o !== 1'b0 || rx_done_o !== 1'b0 ||
        rx_stall_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rsth_outputs data=%h vld=%b done=%b stall=%b busy=%b exp=all 0",
               rx_data_o, rx_data_vld_o, rx_done_o, rx_stall_o, busy_o);
    end
    step();
    rst_n = 1'b1;
    rdy = 1'b1;
    step();
    en = 1'b1;
    step();
    en = 1'b0;
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL rsth_target busy=%b exp=0", busy_o); end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_single_msb();
`ifdef SPI_RX_QUAD_EN
    test_quad_msb();
`else
    test_quad_disabled();
`endif
    test_dual_lsb();
    test_backpressure();
    test_abort();
    test_length_update();
    test_random();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog sim time exceeded, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
